// File: rtl/addsub_arbiter.sv
// addsub_arbiter: two-requester round-robin front end for one shared
// combinational add/subtract unit. A granted operation is latched into the
// datapath operand registers, given one cycle to settle, and its result is
// held in a response register until the consumer accepts it.
// Optional build macro ADDSUB_ARBITER_GRANT_CNT_EN adds per-requester 8-bit
// grant counters (gnt_cnt0, gnt_cnt1).
module addsub_arbiter #(
    parameter int         WIDTH   = 4,
    parameter logic [1:0] ADD_SEL = 2'd0,
    parameter logic [1:0] SUB_SEL = 2'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic [1:0]       dp_select,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    input  logic [WIDTH-1:0] dp_o,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    input  logic             rsp_ready
`ifdef ADDSUB_ARBITER_GRANT_CNT_EN
    ,
    output logic [7:0]       gnt_cnt0,
    output logic [7:0]       gnt_cnt1
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_rr;        // requester that wins a tie
    logic [1:0]       r_sel;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;

    logic             w_idle;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    // Winner selection: a lone valid requester wins, a tie goes to r_rr.
    always_comb begin
        w_idle = (r_state == S_IDLE);
        w_gnt0 = w_idle && req0_valid && (!req1_valid || !r_rr);
        w_gnt1 = w_idle && req1_valid && (!req0_valid ||  r_rr);
        w_op   = w_gnt1 ? req1_op : req0_op;
        w_a    = w_gnt1 ? req1_a  : req0_a;
        w_b    = w_gnt1 ? req1_b  : req0_b;
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign dp_select  = r_sel;
    assign dp_a       = r_a;
    assign dp_b       = r_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;

    // Control FSM: grant in IDLE, settle in EXEC, hold the result in RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr        <= 1'b0;
            r_sel       <= ADD_SEL;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Operands are sampled only here; later requester
                    // changes cannot disturb the operation in flight.
                    if (w_gnt0 || w_gnt1) begin
                        r_sel    <= w_op ? SUB_SEL : ADD_SEL;
                        r_a      <= w_a;
                        r_b      <= w_b;
                        r_rsp_id <= w_gnt1;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_data  <= dp_o;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    // The other requester gets priority after each result.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr        <= ~r_rsp_id;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ADDSUB_ARBITER_GRANT_CNT_EN
    logic [7:0] r_cnt0;
    logic [7:0] r_cnt1;

    // Grant counters, free-running modulo 256.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_gnt0) r_cnt0 <= r_cnt0 + 8'd1;
            if (w_gnt1) r_cnt1 <= r_cnt1 + 8'd1;
        end
    end

    assign gnt_cnt0 = r_cnt0;
    assign gnt_cnt1 = r_cnt1;
`endif

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one combinational 4-bit add/subtract datapath (select, a, b -> o) between two requesters.
- Round-robin arbitration, valid/ready handshake on the request and response sides.
- Drives the datapath operands and select from registers, then captures the result into a response register.
- Sits between the requesting control blocks and the single arithmetic unit instance.

Parameters:
WIDTH, 4, operand/result width; must match the datapath.
ADD_SEL, 0, datapath select code for addition.
SUB_SEL, 1, datapath select code for subtraction.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_op  input  1  0=add, 1=subtract (a-b)
req0_a  input  WIDTH  operand a
req0_b  input  WIDTH  operand b
req0_ready  output  1  requester 0 accepted this cycle
req1_valid, req1_op, req1_a, req1_b, req1_ready  same as requester 0
dp_select  output  2  to datapath select
dp_a  output  WIDTH  to datapath a
dp_b  output  WIDTH  to datapath b
dp_o  input  WIDTH  datapath result (combinational)
rsp_valid  output  1  result available
rsp_id  output  1  requester that owns rsp_data
rsp_data  output  WIDTH  result
rsp_ready  input  1  consumer accepts result

Behaviour:
- Reset (async, active-high): state=IDLE; rsp_valid=0, rsp_id=0, rsp_data=0; dp_select=ADD_SEL, dp_a=0, dp_b=0; rr pointer=0 (requester 0 has priority). Any in-flight operation is discarded and no response is produced.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational and asserted only for the winner in IDLE.
  - Winner: the only valid requester; if both are valid, the requester equal to the rr pointer.
  - On the grant edge: dp_select <= op ? SUB_SEL : ADD_SEL; dp_a, dp_b <= operands; rsp_id <= winner; state -> EXEC.
  - No valid requester: stay in IDLE; dp_* hold their last values.
- EXEC: exactly one cycle for the datapath to settle. rsp_data <= dp_o, rsp_valid <= 1, state -> RESP. Both req ready outputs are 0.
- RESP:
  - rsp_valid=1 and rsp_id, rsp_data are stable until rsp_valid && rsp_ready.
  - On handshake: rsp_valid <= 0, rr pointer <= ~rsp_id, state -> IDLE.
  - Both req ready outputs are 0.
- Latency: grant edge -> rsp_valid high 2 clocks later. Minimum spacing of 3 cycles between grants.
- Arithmetic: unsigned, modulo 2^WIDTH.
  - Add wraps (9+8 -> 1).
  - Subtract wraps (3-5 -> 14).
  - No carry/borrow output.
- dp_select codes 2 and 3 are never driven.
- Requester inputs are sampled only on their grant edge; later changes have no effect on the operation in flight.
- A requester may drop valid before it is granted without side effects.
- rsp_ready while rsp_valid=0 is ignored.
- Fairness: with both requesters valid continuously, grants alternate 0,1,0,1...

Optional Feature:
ADDSUB_ARBITER_GRANT_CNT_EN
- Defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1, 8 bits each.
  - Each counter increments on its requester's grant edge and wraps 255 -> 0.
  - Both clear on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then req0 sub a=5 b=3 with rsp_ready=1 -> req0_ready 1 cycle; dp_select=1, dp_a=5, dp_b=3; rsp_valid 2 clocks after grant with rsp_data=2, rsp_id=0.
- req1 sub a=3 b=5, then req1 add a=9 b=8 -> rsp_data=14, then rsp_data=1, rsp_id=1 for both.
- req0 and req1 held valid for 4 operations (req0 add 1+1, req1 add 2+2) -> grant order 0,1,0,1; rsp_data 2,4,2,4.
- rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stay stable; no req ready pulses; after rsp_ready=1, the next grant occurs 1 cycle after the handshake.
- rst asserted during EXEC of 7-2 -> outputs reset immediately; no response with data 5 ever appears; the next request (add 0+0) completes normally with rsp_id per pointer=0.
- With ADDSUB_ARBITER_GRANT_CNT_EN defined: 3 grants to req0 and 2 to req1 -> gnt_cnt0=3, gnt_cnt1=2; rst clears both to 0.
